// File: rtl/outwrctl.sv
// Buffers quantizer words in a small FIFO and drains one per granted cycle into data memory, stepping the address unit per write.
// One-cycle FIFO latency; in_ready drops on full FIFO or once the job's word count has been accepted.
module outwrctl #(
  parameter int BDBANKA   = 15,
  parameter int BDBANKW   = 64,
  parameter int FIFODEPTH = 4,
  parameter int BCNT      = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               start,
  input  logic [BDBANKA-1:0] baseaddr,
  input  logic [BCNT-1:0]    numwords,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BDBANKW-1:0] in_data,
  output logic               req,
  input  logic               grant,
  output logic               agu_load,
  output logic [BDBANKA-1:0] agu_baseaddr,
  output logic               agu_step,
  output logic               wren,
  output logic [BDBANKW-1:0] wrdata,
  output logic               busy,
  output logic               done
);

  localparam int PW = (FIFODEPTH > 1) ? $clog2(FIFODEPTH) : 1;
  localparam logic [PW:0] DEPTH = (PW+1)'(FIFODEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [BDBANKA-1:0] base_q, base_d;
  logic [BCNT-1:0]    num_q, num_d;
  logic [BCNT-1:0]    acc_q, acc_d;
  logic [BCNT-1:0]    rem_q, rem_d;
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PW:0]        cnt_q, cnt_d;
  logic [BDBANKW-1:0] mem_q [FIFODEPTH];

  logic fifo_nempty;
  logic push;
  logic pop;

  assign fifo_nempty  = (cnt_q != '0);
  assign in_ready     = ((state_q == LOAD) || (state_q == RUN)) && (cnt_q != DEPTH) && (acc_q < num_q);
  assign req          = (state_q == RUN) && fifo_nempty;
  assign wren         = req & grant;
  assign agu_step     = wren;
  assign agu_load     = (state_q == LOAD);
  assign agu_baseaddr = base_q;
  assign busy         = (state_q != IDLE);
  assign done         = (state_q == DONE);
  // Stale storage is masked so an empty FIFO always presents zero.
  assign wrdata       = fifo_nempty ? mem_q[rd_ptr_q] : '0;

  assign push = in_valid & in_ready;
  assign pop  = wren;

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    num_d    = num_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
      acc_d    = acc_q + BCNT'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
      rem_d    = rem_q - BCNT'(1);
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + (PW+1)'(1);
      2'b01:   cnt_d = cnt_q - (PW+1)'(1);
      default: cnt_d = cnt_q;
    endcase

    case (state_q)
      IDLE: begin
        if (start) begin
          if (numwords == '0) begin
            state_d = DONE;
          end else begin
            state_d  = LOAD;
            base_d   = baseaddr;
            num_d    = numwords;
            acc_d    = '0;
            rem_d    = numwords;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
          end
        end
      end
      LOAD: state_d = RUN;
      RUN:  if (pop && (rem_q == BCNT'(1))) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (clr) begin
      state_d  = IDLE;
      base_d   = '0;
      num_d    = '0;
      acc_d    = '0;
      rem_d    = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      base_q   <= '0;
      num_q    <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      num_q    <= num_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

endmodule
